tl_multiway_ctrl: RTL

- Parametrised N-way traffic-light controller. Successor to the fixed highway/country-road pair.
- Way 0 is the main road and rests on green. Side ways 1..N_WAYS-1 get green only after a latched car request, served round-robin, with an all-red clearance between every phase change.
- Contains its own 1 Hz tick prescaler, 2-digit BCD countdown per way, and a night flash mode.
- Feeds the existing seven-segment display decoders directly.

---
 rtl/tl_pkg.sv | 32 +++
 rtl/tl_bcd_down_timer.sv | 40 ++++
 rtl/tl_multiway_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the multi-way traffic-light controller.
// Colours are one-hot {G,Y,R}; timers hold two BCD digits.
package tl_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd2_t;

  typedef enum logic [1:0] {
    ALL_RED,
    GREEN,
    YELLOW,
    FLASH
  } state_e;

  localparam logic [2:0] C_GREEN  = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b010;
  localparam logic [2:0] C_RED    = 3'b001;
  localparam logic [2:0] C_OFF    = 3'b000;

  // Converts a 0..99 second count into two BCD digits at elaboration time.
  function automatic bcd2_t to_bcd2(input int v);
    bcd2_t r;
    r.tens  = 4'((v / 10) % 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/tl_bcd_down_timer.sv
// Two-digit BCD seconds countdown; loads on phase entry and stops at 01.
// o_done pulses on a tick while the value reads 01.
module tl_bcd_down_timer
  import tl_pkg::*;
#(
  parameter bcd2_t RESET_VAL = 8'h01
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_load,
  input  bcd2_t i_load_val,
  input  logic  i_tick,
  output bcd2_t o_value,
  output logic  o_done
);

  bcd2_t r_value;
  logic  w_is_one;

  assign w_is_one = (r_value == bcd2_t'(8'h01));
  assign o_done   = w_is_one & i_tick;
  assign o_value  = r_value;

  // Holding at 01 lets the owner keep a phase alive with the display frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= RESET_VAL;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_tick && !w_is_one && (r_value != '0)) begin
      if (r_value.units == 4'd0) begin
        r_value.units <= 4'd9;
        r_value.tens  <= r_value.tens - 4'd1;
      end else begin
        r_value.units <= r_value.units - 4'd1;
      end
    end
  end

endmodule

// File: rtl/tl_multiway_ctrl.sv
// N-way traffic-light controller: way 0 rests on green, side ways are served
// round-robin on latched requests, with all-red clearance and a night flash mode.
module tl_multiway_ctrl
  import tl_pkg::*;
#(
  parameter int N_WAYS   = 2,
  parameter int CLK_DIV  = 50000000,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 1,
  localparam int AW = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_WAYS-1:0]     i_car_req,
  input  logic                  i_flash_en,
  output logic [3*N_WAYS-1:0]   o_color,
  output logic [8*N_WAYS-1:0]   o_count_bcd,
  output logic [AW-1:0]         o_active_way,
  output logic                  o_tick_1hz
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam bcd2_t BCD_GREEN  = to_bcd2(T_GREEN);
  localparam bcd2_t BCD_YELLOW = to_bcd2(T_YELLOW);
  localparam bcd2_t BCD_ALLRED = to_bcd2(T_ALLRED);
  localparam logic [N_WAYS-1:0] SIDE_MASK = {{(N_WAYS-1){1'b1}}, 1'b0};
  localparam logic [N_WAYS-1:0] ONE_HOT0  = {{(N_WAYS-1){1'b0}}, 1'b1};

  logic [PW-1:0]     r_presc;
  logic [N_WAYS-1:0] r_req_s1;
  logic [N_WAYS-1:0] r_req_s2;
  logic              r_flash_s1;
  logic              r_flash_s2;
  state_e            r_state;
  logic [AW-1:0]     r_active_way;
  logic [AW-1:0]     r_next_way;
  logic [N_WAYS-1:0] r_pending;
  logic              r_blink;

  logic              w_tick;
  logic              w_done;
  bcd2_t             w_timer;
  logic [N_WAYS-1:0] w_busy;
  logic [N_WAYS-1:0] w_pending_lat;
  logic [AW-1:0]     w_scan_way;
  logic              w_flash_go;
  logic              w_leave_flash;
  logic              w_ar_exp;
  logic              w_g_exp;
  logic              w_y_exp;
  logic              w_load;
  bcd2_t             w_load_val;

  assign w_tick     = (r_presc == PW'(CLK_DIV - 1));
  assign o_tick_1hz = w_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc    <= '0;
      r_req_s1   <= '0;
      r_req_s2   <= '0;
      r_flash_s1 <= 1'b0;
      r_flash_s2 <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + PW'(1);
      r_req_s1   <= i_car_req;
      r_req_s2   <= r_req_s1;
      r_flash_s1 <= i_flash_en;
      r_flash_s2 <= r_flash_s1;
    end
  end

  always_comb begin
    w_busy = '0;
    if ((r_state == GREEN) || (r_state == YELLOW)) begin
      w_busy[r_active_way] = 1'b1;
    end
  end

  assign w_pending_lat = (r_state == FLASH) ? '0
                       : ((r_pending | (r_req_s2 & ~w_busy)) & SIDE_MASK);

  // Scanning downwards lets the nearest pending way after the active one win.
  always_comb begin
    w_scan_way = '0;
    for (int k = N_WAYS - 1; k >= 1; k--) begin
      if ((((int'(r_active_way) + k) % N_WAYS) != 0) &&
          r_pending[(int'(r_active_way) + k) % N_WAYS]) begin
        w_scan_way = AW'((int'(r_active_way) + k) % N_WAYS);
      end
    end
  end

  assign w_flash_go    = w_tick & r_flash_s2;
  assign w_leave_flash = (r_state == FLASH)   & w_tick & ~r_flash_s2;
  assign w_ar_exp      = (r_state == ALL_RED) & w_done & ~r_flash_s2;
  assign w_g_exp       = (r_state == GREEN)   & w_done & ~r_flash_s2 &
                         ((r_active_way != '0) | (|r_pending));
  assign w_y_exp       = (r_state == YELLOW)  & w_done & ~r_flash_s2;

  assign w_load     = w_leave_flash | w_ar_exp | w_g_exp | w_y_exp;
  assign w_load_val = w_ar_exp ? BCD_GREEN : (w_g_exp ? BCD_YELLOW : BCD_ALLRED);

  tl_bcd_down_timer #(
    .RESET_VAL (BCD_ALLRED)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (w_tick),
    .o_value    (w_timer),
    .o_done     (w_done)
  );

  // Grant on green entry beats a request latched in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ALL_RED;
      r_active_way <= '0;
      r_next_way   <= '0;
      r_pending    <= '0;
      r_blink      <= 1'b1;
    end else begin
      r_pending <= w_pending_lat;
      if (w_flash_go) begin
        r_state   <= FLASH;
        r_pending <= '0;
        r_blink   <= (r_state == FLASH) ? ~r_blink : 1'b1;
      end else if (w_leave_flash) begin
        r_state    <= ALL_RED;
        r_next_way <= '0;
        r_blink    <= 1'b1;
      end else if (w_ar_exp) begin
        r_state      <= GREEN;
        r_active_way <= r_next_way;
        r_pending    <= w_pending_lat & ~(ONE_HOT0 << r_next_way);
      end else if (w_g_exp) begin
        r_state <= YELLOW;
      end else if (w_y_exp) begin
        r_state    <= ALL_RED;
        r_next_way <= w_scan_way;
      end
    end
  end

  always_comb begin
    o_color      = '0;
    o_count_bcd  = '0;
    o_active_way = r_active_way;
    for (int i = 0; i < N_WAYS; i++) begin
      o_color[3*i +: 3]     = C_RED;
      o_count_bcd[8*i +: 8] = '0;
      if (r_state == FLASH) begin
        o_color[3*i +: 3] = r_blink ? C_YELLOW : C_OFF;
      end else if ((r_state != ALL_RED) && (r_active_way == AW'(i))) begin
        o_color[3*i +: 3]     = (r_state == GREEN) ? C_GREEN : C_YELLOW;
        o_count_bcd[8*i +: 8] = w_timer;
      end
    end
  end

endmodule
